timer_scheduler: RTL and testbench
==================================

Name: timer_scheduler

Overview:
- Multi-channel countdown timer bank with a shared tick, per-channel arm, cancel and periodic-reload control, and a round-robin arbiter that serialises expiry events onto a single valid/ready event port.
- Sits between the prescaler (tick source) and the consumer of timer events; replaces ad-hoc single-timer instances in `top`.
- 8-bit counts match the existing x/y datapath width.

Parameters:
N_TIMERS, 4, number of independent timer channels (power of two, 2..16)
WIDTH, 8, counter and period width in bits
ID_W, clog2(N_TIMERS), channel id width (derived, not overridable)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
tick  in  1  one-cycle count enable from prescaler
load_en  in  1  arm channel load_id this cycle
load_id  in  ID_W  channel to arm
load_value  in  WIDTH  initial count / reload period
load_periodic  in  1  1 = auto-reload on expiry, 0 = one-shot
cancel_en  in  1  disarm channel cancel_id
cancel_id  in  ID_W  channel to disarm
evt_valid  out  1  expiry event presented
evt_ready  in  1  consumer accepts event
evt_id  out  ID_W  channel that expired
evt_overrun  out  1  channel expired again before prior event accepted
active  out  N_TIMERS  per-channel armed flag

Behaviour:
- Reset (async assert, sync release): all channels IDLE, count=0, period=0, pending=0, overrun=0, rr pointer=0; evt_valid=0, evt_id=0, evt_overrun=0, active=0.
- Per-channel state: IDLE or RUNNING, plus independent pending and overrun flags.
- Load, cycle T:
  - count<=load_value, period<=load_value, periodic<=load_periodic, state RUNNING; active visible at T+1.
  - load_value=0 behaves as cancel.
  - Load clears neither pending nor overrun.
- Cancel: state IDLE; pending and overrun cleared.
  - An event already on the port is NOT retracted; it stays until accepted.
- Tick, RUNNING channel:
  - count>1: decrement.
  - count==1: expire. Set pending; if pending already set, also set overrun.
  - On expiry, periodic reloads count<=period and stays RUNNING; one-shot goes IDLE, count=0.
  - IDLE channels ignore tick.
- Simultaneous events on the same channel in one cycle, priority: load > cancel > tick.
  - A load coinciding with an expiry suppresses that expiry.
  - Different channels are fully independent.
- Event port:
  - evt_valid, evt_id and evt_overrun are registered.
  - When evt_valid=0, or a handshake occurs, select the next pending channel round-robin, starting at the rr pointer.
  - Latency: tick expiry at T -> pending at T+1 -> evt_valid at T+2 earliest.
  - While evt_valid=1 and evt_ready=0, all three outputs are held stable.
- Handshake (evt_valid & evt_ready), cycle H:
  - Clear pending and overrun of evt_id; rr pointer <= evt_id+1 (wraps mod N_TIMERS).
  - If the same channel re-expires in cycle H, pending stays set and overrun is cleared.
  - Next event may present at H+1 (back-to-back throughput 1/cycle).
- Selection snapshot: the presented channel's pending and overrun are copied into the output register at selection. Later changes do not alter the presented values.

Decomposition:
- Package timer_scheduler_pkg: N_TIMERS, WIDTH, ID_W constants; chan_state_t enum {IDLE, RUNNING}; chan_t struct {state, periodic, count, period, pending, overrun}.
- Sub-module rr_arbiter: N-bit request vector plus pointer in; one-hot grant and encoded id out; combinational.
- Top holds channel array, priority logic and output register.

Test Plan:
- Reset mid-count: load ch0=5, two ticks, assert rst -> active=0, evt_valid=0 immediately; no event after release despite further ticks.
- One-shot: load ch1=3, one-shot, tick every cycle, evt_ready=1 -> evt_valid=1 with evt_id=1, evt_overrun=0 two cycles after third tick; active[1]=0 afterward.
- Periodic + overrun: load ch2=2, periodic, evt_ready=0, 6 ticks -> evt_id=2, evt_overrun=0 held stable; after accept, next event has evt_overrun=1.
- Round-robin: ch0..ch3 all =1, one tick, evt_ready=1 -> evt_id sequence 0,1,2,3 on consecutive cycles; repeat with pointer at 2 -> 2,3,0,1.
- Collisions: same-cycle load ch3=4 and cancel ch3 while ch3 count==1 with tick -> no event, ch3 count=4, RUNNING.
- Backpressure and cancel: event ch0 presented, evt_ready=0, cancel ch0 -> evt_valid stays 1 with evt_id=0 until accepted; no second event.

Source files
------------

// File: rtl/timer_scheduler_pkg.sv
// Shared constants and channel record for the timer_scheduler bank.
package timer_scheduler_pkg;
  localparam int N_TIMERS = 4;
  localparam int WIDTH    = 8;
  localparam int ID_W     = $clog2(N_TIMERS);

  typedef enum logic {IDLE, RUNNING} chan_state_t;

  typedef struct packed {
    chan_state_t        state;
    logic               periodic;
    logic [WIDTH-1:0]   count;
    logic [WIDTH-1:0]   period;
    logic               pending;
    logic               overrun;
  } chan_t;

  localparam chan_t CHAN_RST = '{state: IDLE, periodic: 1'b0, count: '0,
                                 period: '0, pending: 1'b0, overrun: 1'b0};
endpackage

// File: rtl/timer_scheduler_if.sv
// Control and event-port bundle between the timer bank and its users.
interface timer_scheduler_if import timer_scheduler_pkg::*; ;
  logic                tick;
  logic                load_en;
  logic [ID_W-1:0]     load_id;
  logic [WIDTH-1:0]    load_value;
  logic                load_periodic;
  logic                cancel_en;
  logic [ID_W-1:0]     cancel_id;
  logic                evt_valid;
  logic                evt_ready;
  logic [ID_W-1:0]     evt_id;
  logic                evt_overrun;
  logic [N_TIMERS-1:0] active;

  modport master (
    output tick, load_en, load_id, load_value, load_periodic,
           cancel_en, cancel_id, evt_ready,
    input  evt_valid, evt_id, evt_overrun, active
  );

  modport slave (
    input  tick, load_en, load_id, load_value, load_periodic,
           cancel_en, cancel_id, evt_ready,
    output evt_valid, evt_id, evt_overrun, active
  );
endinterface

// File: rtl/timer_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter import timer_scheduler_pkg::*; (
  input  logic [N_TIMERS-1:0] req,
  input  logic [ID_W-1:0]     ptr,
  output logic [N_TIMERS-1:0] grant,
  output logic [ID_W-1:0]     gid,
  output logic                any
);
  logic [ID_W-1:0] idx;

  always_comb begin
    grant = '0;
    gid   = '0;
    any   = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_TIMERS; k++) begin
      // N_TIMERS is a power of two, so truncation to ID_W performs the wrap
      idx = ptr + ID_W'(k);
      if (!any && req[idx]) begin
        any        = 1'b1;
        gid        = idx;
        grant[idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/timer_scheduler.sv
// Countdown timer bank with per-channel arm/cancel/reload and a registered,
// round-robin serialised expiry event port.
module timer_scheduler import timer_scheduler_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  timer_scheduler_if.slave  bus
);
  chan_t               chans     [N_TIMERS];
  chan_t               chans_nxt [N_TIMERS];
  logic [N_TIMERS-1:0] req, grant, ovr_vec, active_vec;
  logic [ID_W-1:0]     rr_ptr, ptr_eff, gid;
  logic                any, hs;

  always_comb begin
    hs      = bus.evt_valid & bus.evt_ready;
    req     = '0;
    ovr_vec = '0;
    active_vec = '0;
    for (int i = 0; i < N_TIMERS; i++) begin
      req[i]        = chans[i].pending;
      ovr_vec[i]    = chans[i].overrun;
      active_vec[i] = (chans[i].state == RUNNING);
    end
    // The channel being accepted is no longer a candidate this cycle
    if (hs) req[bus.evt_id] = 1'b0;
    ptr_eff = hs ? bus.evt_id + ID_W'(1) : rr_ptr;
  end

  assign bus.active = active_vec;

  rr_arbiter u_arb (
    .req   (req),
    .ptr   (ptr_eff),
    .grant (grant),
    .gid   (gid),
    .any   (any)
  );

  // Per-channel next state; priority load > cancel > tick
  always_comb begin
    for (int i = 0; i < N_TIMERS; i++) begin
      chans_nxt[i] = chans[i];
      if (hs && bus.evt_id == ID_W'(i)) begin
        chans_nxt[i].pending = 1'b0;
        chans_nxt[i].overrun = 1'b0;
      end
      if (bus.load_en && bus.load_id == ID_W'(i) && bus.load_value != '0) begin
        chans_nxt[i].state    = RUNNING;
        chans_nxt[i].count    = bus.load_value;
        chans_nxt[i].period   = bus.load_value;
        chans_nxt[i].periodic = bus.load_periodic;
      end else if ((bus.load_en && bus.load_id == ID_W'(i)) ||
                   (bus.cancel_en && bus.cancel_id == ID_W'(i))) begin
        chans_nxt[i].state   = IDLE;
        chans_nxt[i].count   = '0;
        chans_nxt[i].pending = 1'b0;
        chans_nxt[i].overrun = 1'b0;
      end else if (bus.tick && chans[i].state == RUNNING) begin
        if (chans[i].count > WIDTH'(1)) begin
          chans_nxt[i].count = chans[i].count - WIDTH'(1);
        end else begin
          chans_nxt[i].overrun = chans_nxt[i].overrun | chans_nxt[i].pending;
          chans_nxt[i].pending = 1'b1;
          if (chans[i].periodic) begin
            chans_nxt[i].count = chans[i].period;
          end else begin
            chans_nxt[i].state = IDLE;
            chans_nxt[i].count = '0;
          end
        end
      end
    end
  end

  // Channel registers and event output register (snapshot at selection)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_TIMERS; i++) chans[i] <= CHAN_RST;
      rr_ptr          <= '0;
      bus.evt_valid   <= 1'b0;
      bus.evt_id      <= '0;
      bus.evt_overrun <= 1'b0;
    end else begin
      for (int i = 0; i < N_TIMERS; i++) chans[i] <= chans_nxt[i];
      if (hs) rr_ptr <= bus.evt_id + ID_W'(1);
      if (!bus.evt_valid || hs) begin
        bus.evt_valid   <= any;
        bus.evt_id      <= gid;
        bus.evt_overrun <= |(grant & ovr_vec);
      end
    end
  end
endmodule

// File: tb/tb_timer_scheduler.sv
// Directed scoreboard bench for timer_scheduler: stimulus pushes expected
// events, a negedge monitor pops them on every handshake.
module tb_timer_scheduler;
  import timer_scheduler_pkg::*;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            ovr;
  } evt_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  evt_t exp_q[$];
  evt_t mon_e;

  timer_scheduler_if bus();

  timer_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.evt_valid && bus.evt_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL evt_unexpected actual id=%0d ovr=%0b required=none",
                 bus.evt_id, bus.evt_overrun);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.evt_id !== mon_e.id || bus.evt_overrun !== mon_e.ovr) begin
          failures++;
          $display("FAIL evt_compare actual id=%0d ovr=%0b required id=%0d ovr=%0b",
                   bus.evt_id, bus.evt_overrun, mon_e.id, mon_e.ovr);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int id, input logic ovr);
    evt_t e;
    e.id  = ID_W'(id);
    e.ovr = ovr;
    exp_q.push_back(e);
  endtask

  task automatic load(input int id, input int val, input logic per);
    bus.load_en       = 1'b1;
    bus.load_id       = ID_W'(id);
    bus.load_value    = WIDTH'(val);
    bus.load_periodic = per;
    step(1);
    bus.load_en = 1'b0;
  endtask

  task automatic cancel(input int id);
    bus.cancel_en = 1'b1;
    bus.cancel_id = ID_W'(id);
    step(1);
    bus.cancel_en = 1'b0;
  endtask

  task automatic ticks(input int n);
    bus.tick = 1'b1;
    step(n);
    bus.tick = 1'b0;
  endtask

  initial begin
    bus.tick = 1'b0; bus.load_en = 1'b0; bus.load_id = '0; bus.load_value = '0;
    bus.load_periodic = 1'b0; bus.cancel_en = 1'b0; bus.cancel_id = '0;
    bus.evt_ready = 1'b0;

    // Reset state
    step(3);
    check("rst_valid", int'(bus.evt_valid), 0);
    check("rst_id", int'(bus.evt_id), 0);
    check("rst_ovr", int'(bus.evt_overrun), 0);
    check("rst_active", int'(bus.active), 0);
    rst = 1'b0;
    step(1);

    // Round-robin from pointer 0: all four expire on the same tick
    bus.evt_ready = 1'b1;
    for (int c = 0; c < 4; c++) load(c, 1, 1'b0);
    for (int c = 0; c < 4; c++) push(c, 1'b0);
    ticks(1);
    check("rr0_latency", int'(bus.evt_valid), 0);
    for (int k = 0; k < 4; k++) begin
      step(1);
      check("rr0_valid", int'(bus.evt_valid), 1);
      check("rr0_id", int'(bus.evt_id), k);
    end
    step(1);
    check("rr0_drained", int'(bus.evt_valid), 0);

    // Move pointer to 2 by accepting a ch1 event, then repeat: 2,3,0,1
    load(1, 1, 1'b0);
    push(1, 1'b0);
    ticks(1);
    step(3);
    for (int c = 0; c < 4; c++) load(c, 1, 1'b0);
    push(2, 1'b0); push(3, 1'b0); push(0, 1'b0); push(1, 1'b0);
    ticks(1);
    for (int k = 0; k < 4; k++) begin
      step(1);
      check("rr2_id", int'(bus.evt_id), (2 + k) % 4);
    end
    step(1);
    check("rr2_drained", int'(bus.evt_valid), 0);

    // One-shot ch1 = 3
    load(1, 3, 1'b0);
    check("os_active", int'(bus.active[1]), 1);
    push(1, 1'b0);
    ticks(3);
    check("os_latency", int'(bus.evt_valid), 0);
    check("os_idle", int'(bus.active[1]), 0);
    step(1);
    check("os_valid", int'(bus.evt_valid), 1);
    check("os_id", int'(bus.evt_id), 1);
    check("os_ovr", int'(bus.evt_overrun), 0);
    step(2);
    check("os_done", int'(bus.evt_valid), 0);

    // Periodic ch2 = 2 under backpressure; snapshot stays ovr=0
    bus.evt_ready = 1'b0;
    load(2, 2, 1'b1);
    bus.tick = 1'b1;
    step(3);
    check("per_valid", int'(bus.evt_valid), 1);
    check("per_id", int'(bus.evt_id), 2);
    check("per_ovr", int'(bus.evt_overrun), 0);
    step(3);
    bus.tick = 1'b0;
    check("per_hold_id", int'(bus.evt_id), 2);
    check("per_hold_ovr", int'(bus.evt_overrun), 0);
    // ch1 period 1 expires twice while ch2 is held -> its event carries overrun
    load(1, 1, 1'b1);
    ticks(2);
    check("per_hold2_id", int'(bus.evt_id), 2);
    check("per_hold2_ovr", int'(bus.evt_overrun), 0);
    push(2, 1'b0);
    push(1, 1'b1);
    bus.evt_ready = 1'b1;
    step(1);
    check("ovr_valid", int'(bus.evt_valid), 1);
    check("ovr_id", int'(bus.evt_id), 1);
    check("ovr_flag", int'(bus.evt_overrun), 1);
    step(1);
    check("ovr_done", int'(bus.evt_valid), 0);
    cancel(1);
    cancel(2);
    check("per_cancelled", int'(bus.active), 0);

    // Collision: load ch3=4 + cancel ch3 + tick while count==1
    load(3, 1, 1'b0);
    bus.load_en = 1'b1; bus.load_id = 2'd3; bus.load_value = 8'd4;
    bus.load_periodic = 1'b0;
    bus.cancel_en = 1'b1; bus.cancel_id = 2'd3;
    bus.tick = 1'b1;
    step(1);
    bus.load_en = 1'b0; bus.cancel_en = 1'b0; bus.tick = 1'b0;
    check("col_active", int'(bus.active), 8);
    step(2);
    check("col_noevt", int'(bus.evt_valid), 0);
    ticks(3);
    step(2);
    check("col_count", int'(bus.evt_valid), 0);
    push(3, 1'b0);
    ticks(1);
    step(1);
    check("col_valid", int'(bus.evt_valid), 1);
    check("col_id", int'(bus.evt_id), 3);
    step(1);
    check("col_idle", int'(bus.active), 0);

    // Backpressure then cancel: presented event is not retracted
    bus.evt_ready = 1'b0;
    load(0, 1, 1'b0);
    ticks(1);
    step(1);
    check("bp_valid", int'(bus.evt_valid), 1);
    cancel(0);
    step(2);
    check("bp_hold_valid", int'(bus.evt_valid), 1);
    check("bp_hold_id", int'(bus.evt_id), 0);
    push(0, 1'b0);
    bus.evt_ready = 1'b1;
    step(1);
    check("bp_accepted", int'(bus.evt_valid), 0);
    step(3);
    check("bp_no_second", int'(bus.evt_valid), 0);

    // Reset in mid-count with an event on the port
    bus.evt_ready = 1'b0;
    load(0, 5, 1'b1);
    load(1, 1, 1'b0);
    ticks(2);
    check("mrst_pre_valid", int'(bus.evt_valid), 1);
    check("mrst_pre_active", int'(bus.active), 1);
    rst = 1'b1;
    #1;
    check("mrst_valid", int'(bus.evt_valid), 0);
    check("mrst_active", int'(bus.active), 0);
    step(2);
    rst = 1'b0;
    bus.evt_ready = 1'b1;
    ticks(8);
    step(3);
    check("mrst_after_valid", int'(bus.evt_valid), 0);
    check("mrst_after_active", int'(bus.active), 0);

    check("scoreboard_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
